// File: rtl/exec_trace_buffer.sv
// rtl/exec_trace_buffer.sv - retirement trace capture with armed trigger, post-trigger window and oldest-first readout
module exec_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       retire_valid,
    input  logic [XLEN-1:0]            retire_pc,
    input  logic [31:0]                retire_inst,
    input  logic [4:0]                 retire_rd,
    input  logic                       retire_we,
    input  logic [XLEN-1:0]            retire_wdata,
    input  logic                       arm,
    input  logic                       trig_pc_en,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       trig_ext,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [31:0]                rd_inst,
    output logic [4:0]                 rd_rd,
    output logic                       rd_we,
    output logic [XLEN-1:0]            rd_wdata,
    output logic                       rd_last,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] POST_LIM = CW'(POST_TRIG);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic            overflow_q, overflow_d;
    logic            wr_en;
    logic            enter_done;
    logic            trig_hit;

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [31:0]     mem_inst_q  [DEPTH];
    logic [4:0]      mem_rd_q    [DEPTH];
    logic            mem_we_q    [DEPTH];
    logic [XLEN-1:0] mem_wdata_q [DEPTH];

    assign trig_hit = trig_ext || (trig_pc_en && retire_valid && (retire_pc == trig_pc));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        post_cnt_d  = post_cnt_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        enter_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d    = S_ARMED;
                    wr_ptr_d   = '0;
                    count_d    = '0;
                    post_cnt_d = '0;
                    overflow_d = 1'b0;
                end
            end
            S_ARMED, S_POST: begin
                if (retire_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    // A full buffer keeps its count; the write lands on the oldest slot.
                    if (count_q == CNT_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                if (state_q == S_ARMED) begin
                    if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                            enter_done = 1'b1;
                        end else begin
                            state_d    = S_POST;
                            post_cnt_d = '0;
                        end
                    end
                end else if (retire_valid) begin
                    post_cnt_d = post_cnt_q + CNT_ONE;
                    if (post_cnt_d == POST_LIM) begin
                        enter_done = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (remaining_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_ready) begin
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Readout starts at the oldest record, using post-write pointer and count.
        if (enter_done) begin
            state_d     = S_DONE;
            rd_ptr_d    = wr_ptr_d - count_d[AW-1:0];
            remaining_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            post_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            post_cnt_q  <= post_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_pc_q[wr_ptr_q]    <= retire_pc;
            mem_inst_q[wr_ptr_q]  <= retire_inst;
            mem_rd_q[wr_ptr_q]    <= retire_rd;
            mem_we_q[wr_ptr_q]    <= retire_we;
            mem_wdata_q[wr_ptr_q] <= retire_wdata;
        end
    end

    // Fields are forced to zero whenever no record is offered.
    assign rd_valid = (state_q == S_DONE) && (remaining_q != '0);
    assign rd_last  = rd_valid && (remaining_q == CNT_ONE);
    assign rd_pc    = rd_valid ? mem_pc_q[rd_ptr_q]    : '0;
    assign rd_inst  = rd_valid ? mem_inst_q[rd_ptr_q]  : '0;
    assign rd_rd    = rd_valid ? mem_rd_q[rd_ptr_q]    : '0;
    assign rd_we    = rd_valid ? mem_we_q[rd_ptr_q]    : 1'b0;
    assign rd_wdata = rd_valid ? mem_wdata_q[rd_ptr_q] : '0;
    assign state_o  = state_q;
    assign count_o  = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb/tb_exec_trace_buffer.sv - directed checks for exec_trace_buffer (POST_TRIG=4 and POST_TRIG=0 builds)
module tb_exec_trace_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic [31:0] retire_inst = '0;
    logic [4:0]  retire_rd = '0;
    logic        retire_we = 1'b0;
    logic [31:0] retire_wdata = '0;
    logic        arm = 1'b0;
    logic        trig_pc_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        trig_ext = 1'b0;
    logic        rd_ready = 1'b0;

    logic        a_valid, a_we, a_last, a_ovf;
    logic [31:0] a_pc, a_inst, a_wdata;
    logic [4:0]  a_rd, a_count;
    logic [1:0]  a_state;

    logic        b_valid, b_we, b_last, b_ovf;
    logic [31:0] b_pc, b_inst, b_wdata;
    logic [4:0]  b_rd, b_count;
    logic [1:0]  b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(4)) u_dut (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_inst(retire_inst), .retire_rd(retire_rd), .retire_we(retire_we),
        .retire_wdata(retire_wdata), .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .trig_ext(trig_ext), .rd_valid(a_valid), .rd_ready(rd_ready), .rd_pc(a_pc),
        .rd_inst(a_inst), .rd_rd(a_rd), .rd_we(a_we), .rd_wdata(a_wdata), .rd_last(a_last),
        .state_o(a_state), .count_o(a_count), .overflow(a_ovf)
    );

    exec_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(0)) u_dut_p0 (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_inst(retire_inst), .retire_rd(retire_rd), .retire_we(retire_we),
        .retire_wdata(retire_wdata), .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .trig_ext(trig_ext), .rd_valid(b_valid), .rd_ready(rd_ready), .rd_pc(b_pc),
        .rd_inst(b_inst), .rd_rd(b_rd), .rd_we(b_we), .rd_wdata(b_wdata), .rd_last(b_last),
        .state_o(b_state), .count_o(b_count), .overflow(b_ovf)
    );

    function automatic logic [31:0] f_inst(input logic [31:0] pc);
        return pc ^ 32'h00A0_0093;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [31:0] pc);
        return ~pc + 32'h0000_1000;
    endfunction

    // Expected readout record: {pc, inst, rd, we, wdata, last}
    function automatic logic [101:0] f_rec(input logic [31:0] pc, input logic last);
        return {pc, f_inst(pc), pc[6:2], pc[2], f_wdata(pc), last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_retire(input logic [31:0] pc, input logic ext);
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_inst  = f_inst(pc);
        retire_rd    = pc[6:2];
        retire_we    = pc[2];
        retire_wdata = f_wdata(pc);
        trig_ext     = ext;
        step();
        retire_valid = 1'b0;
        trig_ext     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic capture_pc_trigger();
        do_arm();
        trig_pc_en = 1'b1;
        trig_pc    = 32'h08;
        for (int i = 0; i < 8; i++) do_retire(32'(4 * i), 1'b0);
        trig_pc_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_state, a_count, a_ovf, a_valid, a_last, a_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d count=%0d ovf=%0b valid=%0b last=%0b pc=%h, required all 0",
                     a_state, a_count, a_ovf, a_valid, a_last, a_pc);
        end
    endtask

    task automatic test_pc_trigger();
        int n = 0;
        do_reset();
        do_arm();
        checks++;
        if (a_state !== 2'd1) begin
            errors++; $display("FAIL arm_state: got %0d required 1", a_state);
        end
        capture_pc_trigger();
        checks++;
        if ({a_state, a_count, a_ovf} !== {2'd3, 5'd7, 1'b0}) begin
            errors++;
            $display("FAIL pc_trig_capture: state=%0d count=%0d ovf=%0b, required 3/7/0", a_state, a_count, a_ovf);
        end
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 7; cyc++) begin
            if (a_valid) begin
                checks++;
                if ({a_pc, a_inst, a_rd, a_we, a_wdata, a_last} !== f_rec(32'(4 * n), n == 6)) begin
                    errors++;
                    $display("FAIL pc_trig_record%0d: got pc=%h last=%0b required pc=%h last=%0b",
                             n, a_pc, a_last, 4 * n, n == 6);
                end
                n++;
            end
            step();
        end
        rd_ready = 1'b0;
        checks++;
        if ({n[3:0], a_state, a_valid} !== {4'd7, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL pc_trig_end: transfers=%0d state=%0d valid=%0b, required 7/0/0", n, a_state, a_valid);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [31:0] held_pc;
        do_reset();
        capture_pc_trigger();
        rd_ready = 1'b0;
        held_pc  = '0;
        for (int cyc = 0; cyc < 60 && n < 7; cyc++) begin
            if (a_valid) begin
                checks++;
                if ({a_pc, a_inst, a_rd, a_we, a_wdata, a_last} !== f_rec(32'(4 * n), n == 6)) begin
                    errors++;
                    $display("FAIL bp_record%0d: got pc=%h last=%0b required pc=%h last=%0b",
                             n, a_pc, a_last, 4 * n, n == 6);
                end
                if (rd_ready) n++;
            end
            step();
            rd_ready = ~rd_ready;
        end
        rd_ready = 1'b0;
        step();
        step();
        checks++;
        if ({n[3:0], a_state, a_valid} !== {4'd7, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_end: transfers=%0d state=%0d valid=%0b, required 7/0/0", n, a_state, a_valid);
        end
    endtask

    task automatic test_wrap_and_arm_in_done();
        int n = 0;
        do_reset();
        do_arm();
        for (int i = 0; i < 20; i++) do_retire(32'h100 + 32'(4 * i), 1'b0);
        checks++;
        if ({a_state, a_count, a_ovf} !== {2'd1, 5'd16, 1'b1}) begin
            errors++;
            $display("FAIL wrap_pre_trig: state=%0d count=%0d ovf=%0b, required 1/16/1", a_state, a_count, a_ovf);
        end
        do_retire(32'h150, 1'b1);
        for (int i = 1; i <= 4; i++) do_retire(32'h150 + 32'(4 * i), 1'b0);
        checks++;
        if ({a_state, a_count, a_ovf} !== {2'd3, 5'd16, 1'b1}) begin
            errors++;
            $display("FAIL wrap_capture: state=%0d count=%0d ovf=%0b, required 3/16/1", a_state, a_count, a_ovf);
        end
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 16; cyc++) begin
            arm = (n == 5);
            if (a_valid) begin
                checks++;
                if ({a_pc, a_inst, a_rd, a_we, a_wdata, a_last} !== f_rec(32'h124 + 32'(4 * n), n == 15)) begin
                    errors++;
                    $display("FAIL wrap_record%0d: got pc=%h last=%0b required pc=%h last=%0b",
                             n, a_pc, a_last, 32'h124 + 4 * n, n == 15);
                end
                n++;
            end
            step();
        end
        arm      = 1'b0;
        rd_ready = 1'b0;
        checks++;
        if ({n[4:0], a_state, a_count, a_ovf} !== {5'd16, 2'd0, 5'd16, 1'b1}) begin
            errors++;
            $display("FAIL wrap_end: transfers=%0d state=%0d count=%0d ovf=%0b, required 16/0/16/1",
                     n, a_state, a_count, a_ovf);
        end
        do_arm();
        checks++;
        if ({a_state, a_count, a_ovf} !== {2'd1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL rearm_clear: state=%0d count=%0d ovf=%0b, required 1/0/0", a_state, a_count, a_ovf);
        end
    endtask

    task automatic test_reset_mid_post();
        do_reset();
        do_arm();
        trig_pc_en = 1'b1;
        trig_pc    = 32'h08;
        for (int i = 0; i < 5; i++) do_retire(32'(4 * i), 1'b0);
        trig_pc_en = 1'b0;
        checks++;
        if ({a_state, a_count} !== {2'd2, 5'd5}) begin
            errors++;
            $display("FAIL mid_post_state: state=%0d count=%0d, required 2/5", a_state, a_count);
        end
        do_reset();
        checks++;
        if ({a_state, a_count, a_ovf, a_valid} !== {2'd0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_post_reset: state=%0d count=%0d ovf=%0b valid=%0b, required all 0",
                     a_state, a_count, a_ovf, a_valid);
        end
        for (int i = 0; i < 3; i++) do_retire(32'h40 + 32'(4 * i), 1'b1);
        checks++;
        if ({a_state, a_count, a_valid} !== {2'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL idle_ignores_retire: state=%0d count=%0d valid=%0b, required 0/0/0",
                     a_state, a_count, a_valid);
        end
    endtask

    task automatic test_arm_with_trig_and_empty_done();
        do_reset();
        arm      = 1'b1;
        trig_ext = 1'b1;
        step();
        arm      = 1'b0;
        trig_ext = 1'b0;
        checks++;
        if ({a_state, b_state} !== {2'd1, 2'd1}) begin
            errors++;
            $display("FAIL arm_trig_idle: states=%0d/%0d, required 1/1", a_state, b_state);
        end
        step();
        checks++;
        if (b_state !== 2'd1) begin
            errors++; $display("FAIL trig_not_latched: got %0d required 1", b_state);
        end
        trig_ext = 1'b1;
        step();
        trig_ext = 1'b0;
        checks++;
        if ({b_state, b_count, b_valid, a_state, a_count} !== {2'd3, 5'd0, 1'b0, 2'd2, 5'd0}) begin
            errors++;
            $display("FAIL empty_done: p0 state=%0d count=%0d valid=%0b, p4 state=%0d count=%0d, required 3/0/0 2/0",
                     b_state, b_count, b_valid, a_state, a_count);
        end
        step();
        checks++;
        if ({b_state, b_valid} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL empty_done_exit: state=%0d valid=%0b, required 0/0", b_state, b_valid);
        end
    endtask

    initial begin
        reset = 1'b0;
        step();
        test_reset();
        test_pc_trigger();
        test_backpressure();
        test_wrap_and_arm_in_done();
        test_reset_mid_post();
        test_arm_with_trig_and_empty_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_trace_buffer.md
Name: exec_trace_buffer

Overview:
Synthesizable retirement-trace capture block for the single-cycle RV32I core. It turns the bench-only per-cycle execution monitor into hardware. It records retired-instruction records (PC, instruction, rd, write-back data) into a parametrised circular buffer. Recording is armed, triggered by a PC match or an external event, continues for a programmable post-trigger window, then freezes. Records are streamed out oldest-first over a valid/ready port.

Parameters:
XLEN, 32, data/address width of PC, instruction and write-back fields
DEPTH, 16, buffer entries; power of two, >= 2
POST_TRIG, 4, records captured after the trigger record; 0 <= POST_TRIG < DEPTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
retire_valid  in  1  one instruction retires this cycle
retire_pc  in  XLEN  PC of retiring instruction
retire_inst  in  32  instruction word
retire_rd  in  5  destination register
retire_we  in  1  register write enable (RUWr)
retire_wdata  in  XLEN  write-back data
arm  in  1  start capture (honoured only in IDLE)
trig_pc_en  in  1  enable PC-match trigger
trig_pc  in  XLEN  trigger PC
trig_ext  in  1  external trigger pulse
rd_valid  out  1  readout record available
rd_ready  in  1  consumer accepts record
rd_pc  out  XLEN  record PC
rd_inst  out  32  record instruction
rd_rd  out  5  record rd
rd_we  out  1  record write enable
rd_wdata  out  XLEN  record write-back data
rd_last  out  1  current record is the final one
state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
count_o  out  $clog2(DEPTH)+1  valid records held
overflow  out  1  sticky: oldest records were overwritten

Behaviour:
- Reset (reset==0 at posedge): state IDLE, wr_ptr=0, count=0, post_cnt=0, overflow=0. All outputs are 0. Reset in any state aborts capture or readout immediately.
- IDLE: retire and trigger inputs are ignored. arm -> ARMED next cycle; clears count, wr_ptr and overflow. arm and a trigger in the same IDLE cycle: the trigger is ignored.
- Capture (ARMED, POST): each retire_valid cycle writes a record at wr_ptr, increments wr_ptr mod DEPTH, and increments count saturating at DEPTH. A write while count==DEPTH overwrites the oldest record and sets overflow.
- Trigger condition, evaluated only in ARMED: trig_ext OR (trig_pc_en AND retire_valid AND retire_pc==trig_pc). The trigger-cycle record, if any, is captured.
- ARMED on trigger: -> POST with post_cnt=0, or -> DONE directly if POST_TRIG==0.
- POST: each captured record increments post_cnt. The record making post_cnt==POST_TRIG is written, and state goes to DONE next cycle. Later retires are ignored.
- DONE entry: rd_ptr=(wr_ptr-count) mod DEPTH and remaining=count. If count==0, return to IDLE next cycle with rd_valid never asserted.
- DONE readout:
  - rd_valid=1 while remaining>0; rd_* fields show the buffer at rd_ptr, combinational from the registered pointer.
  - Fields are held stable until accepted. rd_valid&rd_ready advances rd_ptr (mod DEPTH) and decrements remaining.
  - rd_last=rd_valid&&(remaining==1). Accepting the last record -> IDLE next cycle.
  - arm and triggers are ignored in DONE.
- count_o and overflow hold their values through DONE and are cleared only by arm or reset.

Test Plan:
- DEPTH=16, POST_TRIG=4; arm; retire 8 records pc=0x00..0x1C step 4, trig_pc_en=1, trig_pc=0x08 -> capture stops after pc 0x18, pc 0x1C ignored; count_o=7, overflow=0; readout pc 0x00..0x18 in order, rd_last only on 0x18, then state_o=0.
- Wrap: arm; 20 records pc=0x100+4i, no trigger; trig_ext with record 20 (pc 0x150); 4 more records -> count_o=16, overflow=1; readout starts at pc 0x124, ends at 0x160 with rd_last.
- Backpressure: run the first scenario with rd_ready toggling every cycle -> each record held stable while rd_ready=0; exactly 7 transfers, no duplicates or skips.
- Reset mid-POST: after the trigger plus 2 records, drive reset=0 for one cycle -> state_o=0, count_o=0, overflow=0, rd_valid=0; later retires are ignored.
- arm and trig_ext together in IDLE -> state_o=1 next cycle, trigger ignored; a subsequent trig_ext with no retire_valid, POST_TRIG=0 build -> DONE with count_o=0, rd_valid stays 0, IDLE next cycle.
- arm pulsed during DONE readout -> ignored; readout completes unchanged; count_o is preserved until the next arm in IDLE.
